// File: rtl/blinky_pkg.sv
// Shared register map for the multi-channel pattern blinker.
// Holds the bus register offsets and the CTRL bit layout.
package blinky_pkg;

    localparam logic REG_MASK = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ONESHOT = 1;
    localparam int unsigned CTRL_DONE    = 2;

    // CTRL read value; bits above DONE read as zero.
    function automatic logic [CTRL_DONE:0] ctrl_word(input logic en,
                                                     input logic oneshot,
                                                     input logic done);
        logic [CTRL_DONE:0] w;
        w               = '0;
        w[CTRL_EN]      = en;
        w[CTRL_ONESHOT] = oneshot;
        w[CTRL_DONE]    = done;
        return w;
    endfunction

endpackage

// File: rtl/blinky_channel.sv
// One LED channel: rotating pattern register, step counter, control bits and
// the registered active-low LED drive.
module blinky_channel
    import blinky_pkg::*;
#(
    parameter int unsigned MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              mask_we,
    input  logic              ctrl_we,
    input  logic [MASK_W-1:0] wdata,
    output logic [MASK_W-1:0] work,
    output logic              en,
    output logic              oneshot,
    output logic              done,
    output logic              led
);

    localparam int unsigned SW = $clog2(MASK_W);
    localparam logic [SW-1:0] LAST = SW'(MASK_W - 1);

    logic [SW-1:0] step;

    // A bus write always wins over a coincident tick for this channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            work    <= '0;
            step    <= '0;
            en      <= 1'b0;
            oneshot <= 1'b0;
            done    <= 1'b0;
            led     <= 1'b1;
        end else if (mask_we) begin
            work <= wdata;
            step <= '0;
            done <= 1'b0;
            led  <= 1'b1;
        end else if (ctrl_we) begin
            en      <= wdata[CTRL_EN];
            oneshot <= wdata[CTRL_ONESHOT];
        end else if (tick) begin
            if (en && !done) begin
                led  <= ~work[MASK_W-1];
                work <= {work[MASK_W-2:0], work[MASK_W-1]};
                step <= (step == LAST) ? '0 : step + 1'b1;
                if (oneshot && (step == LAST)) begin
                    done <= 1'b1;
                end
            end else begin
                led <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wish_blinky_multi.sv
// Bus-programmable bank of NCH pattern blinkers sharing one step prescaler.
// Single-cycle acknowledged register access; ADR_I[0] selects MASK/CTRL.
module wish_blinky_multi
    import blinky_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned MASK_W   = 8,
    parameter int unsigned TICK_DIV = 4000000
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 STB_I,
    input  logic                 WE_I,
    input  logic [$clog2(NCH):0] ADR_I,
    input  logic [MASK_W-1:0]    DAT_I,
    output logic [MASK_W-1:0]    DAT_O,
    output logic                 ACK_O,
    output logic [NCH-1:0]       oN_led
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0]     prescale;
    logic              tick;
    logic [IW-1:0]     idx;
    logic              sel_ctrl;
    logic              access;
    logic [MASK_W-1:0] work [NCH];
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    oneshot;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    mask_we;
    logic [NCH-1:0]    ctrl_we;
    logic [MASK_W-1:0] rdata;

    generate
        if (NCH > 1) begin : g_idx
            assign idx = ADR_I[IW:1];
        end else begin : g_idx_single
            assign idx = '0;
        end
    endgenerate

    assign sel_ctrl = ADR_I[0];
    // A held strobe is accepted only every other cycle, while ACK_O is low.
    assign access   = STB_I & ~ACK_O;
    assign tick     = (prescale == CW'(TICK_DIV - 1));

    // Free-running; bus writes never restart it.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // Channel indices with no instance decode to nothing: writes vanish, reads give 0.
    always_comb begin
        mask_we = '0;
        ctrl_we = '0;
        rdata   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(idx) == i) begin
                mask_we[i] = access & WE_I & (sel_ctrl == REG_MASK);
                ctrl_we[i] = access & WE_I & (sel_ctrl == REG_CTRL);
                rdata      = (sel_ctrl == REG_CTRL)
                           ? MASK_W'(ctrl_word(en[i], oneshot[i], done[i]))
                           : work[i];
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ACK_O <= 1'b0;
            DAT_O <= '0;
        end else begin
            ACK_O <= access;
            DAT_O <= (access && !WE_I) ? rdata : '0;
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            blinky_channel #(
                .MASK_W(MASK_W)
            ) u_channel (
                .clk    (CLK_I),
                .rst    (RST_I),
                .tick   (tick),
                .mask_we(mask_we[i]),
                .ctrl_we(ctrl_we[i]),
                .wdata  (DAT_I),
                .work   (work[i]),
                .en     (en[i]),
                .oneshot(oneshot[i]),
                .done   (done[i]),
                .led    (oN_led[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_wish_blinky_multi.sv
// Scoreboard bench for wish_blinky_multi: a pattern/position reference model
// predicts LEDs and read data; a second NCH=3 instance probes unmapped channel 3.
module tb_wish_blinky_multi;

    localparam int NCH      = 2;
    localparam int MASK_W   = 8;
    localparam int TICK_DIV = 4;

    logic       clk;
    logic       rst;
    logic       stb, we;
    logic [1:0] adr;
    logic [7:0] dat;
    logic [7:0] dat_o;
    logic       ack;
    logic [1:0] led;

    logic       stb2, we2;
    logic [2:0] adr2;
    logic [7:0] dat2;
    logic [7:0] dat_o2;
    logic       ack2;
    logic [2:0] led2;

    wish_blinky_multi #(.NCH(NCH), .MASK_W(MASK_W), .TICK_DIV(TICK_DIV)) dut (
        .CLK_I(clk), .RST_I(rst), .STB_I(stb), .WE_I(we), .ADR_I(adr),
        .DAT_I(dat), .DAT_O(dat_o), .ACK_O(ack), .oN_led(led)
    );

    wish_blinky_multi #(.NCH(3), .MASK_W(MASK_W), .TICK_DIV(TICK_DIV)) dut3 (
        .CLK_I(clk), .RST_I(rst), .STB_I(stb2), .WE_I(we2), .ADR_I(adr2),
        .DAT_I(dat2), .DAT_O(dat_o2), .ACK_O(ack2), .oN_led(led2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel remembers the pattern as written plus how
    // many steps it has advanced; the visible register is that pattern rotated.
    logic [7:0] m_mask [NCH];
    int         m_pos  [NCH];
    bit         m_en   [NCH];
    bit         m_os   [NCH];
    bit         m_done [NCH];
    bit         m_led  [NCH];
    int         m_cnt;
    bit         m_ack;

    typedef struct packed {
        logic       is_read;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (MASK_W - n));
    endfunction

    always @(posedge clk) begin
        bit   tk, acc, rg;
        int   c;
        exp_t e;
        if (rst) begin
            m_cnt = 0;
            m_ack = 0;
            for (int k = 0; k < NCH; k++) begin
                m_mask[k] = 8'h00; m_pos[k] = 0; m_en[k] = 0;
                m_os[k] = 0; m_done[k] = 0; m_led[k] = 1;
            end
            sb.delete();
        end else begin
            tk    = (m_cnt == TICK_DIV - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            acc   = stb && !m_ack;
            c     = int'(adr[1]);
            rg    = adr[0];
            if (acc) begin
                e.is_read = !we;
                e.data    = 8'h00;
                if (!we)
                    e.data = rg ? {5'b0, m_done[c], m_os[c], m_en[c]}
                                : rotl(m_mask[c], m_pos[c]);
                sb.push_back(e);
            end
            for (int k = 0; k < NCH; k++) begin
                if (acc && we && c == k) begin
                    if (!rg) begin
                        m_mask[k] = dat; m_pos[k] = 0; m_done[k] = 0; m_led[k] = 1;
                    end else begin
                        m_en[k] = dat[0]; m_os[k] = dat[1];
                    end
                end else if (tk) begin
                    if (m_en[k] && !m_done[k]) begin
                        m_led[k] = ~m_mask[k][MASK_W-1-m_pos[k]];
                        if (m_os[k] && m_pos[k] == MASK_W - 1) m_done[k] = 1;
                        m_pos[k] = (m_pos[k] + 1) % MASK_W;
                    end else begin
                        m_led[k] = 1;
                    end
                end
            end
            m_ack = acc;
        end
    end

    // Monitor: LEDs every cycle; every ACK must match a queued transfer.
    always @(negedge clk) begin
        exp_t e;
        if (chk_on) begin
            for (int k = 0; k < NCH; k++)
                check($sformatf("led%0d", k), {31'b0, led[k]}, {31'b0, m_led[k]});
            check("ack", {31'b0, ack}, {31'b0, (sb.size() != 0)});
            if (ack && sb.size() != 0) begin
                e = sb.pop_front();
                if (e.is_read) check("dat_o", {24'b0, dat_o}, {24'b0, e.data});
            end
        end
    end

    task automatic bus(input bit w, input int ch, input bit rg, input logic [7:0] d,
                       input bit align = 0);
        int waited = 0;
        if (align) begin
            do begin @(negedge clk); waited++; end
            while (m_cnt != TICK_DIV - 1 && waited < 4 * TICK_DIV);
            waited = 0;
        end else begin
            @(negedge clk);
        end
        stb = 1; we = w; adr = {ch[0], rg}; dat = d;
        do begin @(negedge clk); waited++; end while (!ack && waited < 8);
        if (!ack) begin
            n_checks++; n_fail++;
            $display("FAIL bus_timeout: no ACK after %0d cycles, expected 1", waited);
        end
        stb = 0;
    endtask

    task automatic bus3(input bit w, input logic [1:0] ch, input bit rg, input logic [7:0] d,
                        output logic [7:0] rd, output logic first_ack);
        int waited = 1;
        @(negedge clk);
        stb2 = 1; we2 = w; adr2 = {ch, rg}; dat2 = d;
        @(negedge clk);
        first_ack = ack2;
        while (!ack2 && waited < 8) begin @(negedge clk); waited++; end
        rd   = dat_o2;
        stb2 = 0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TICK_DIV) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd;
        logic       fa;
        logic [3:0] ack_seq;
        int         guard;
        rst = 1; stb = 0; we = 0; adr = '0; dat = '0;
        stb2 = 0; we2 = 0; adr2 = '0; dat2 = '0;
        @(posedge clk);
        @(negedge clk);
        chk_on = 1;
        @(negedge clk);
        rst = 0;

        // Free-running pattern A5 on channel 0, channel 1 idle.
        bus(1, 0, 0, 8'hA5);
        bus(1, 0, 1, 8'h01);
        wait_ticks(10);
        bus(0, 0, 1, 8'h00);

        // One-shot F0 on channel 1, then status readback.
        bus(1, 1, 0, 8'hF0);
        bus(1, 1, 1, 8'h03);
        wait_ticks(10);
        bus(0, 1, 1, 8'h00);
        bus(0, 1, 0, 8'h00);

        // MASK write landing exactly on a tick edge while channel 1 rotates.
        bus(1, 1, 0, 8'h3C);
        bus(1, 1, 1, 8'h01);
        wait_ticks(1);
        bus(1, 0, 0, 8'h81, 1);
        bus(0, 0, 0, 8'h00);
        wait_ticks(3);

        // Pause after three steps and resume from the held position.
        bus(1, 0, 0, 8'hA5);
        guard = 0;
        while (m_pos[0] != 3 && guard < 64) begin @(negedge clk); guard++; end
        check("pos3_reached", guard < 64 ? 32'd1 : 32'd0, 32'd1);
        bus(1, 0, 1, 8'h00);
        wait_ticks(3);
        bus(1, 0, 1, 8'h01);
        wait_ticks(6);

        // Strobe held for four cycles.
        @(negedge clk);
        stb = 1; we = 0; adr = 2'b00;
        ack_seq[3] = ack;
        @(negedge clk); ack_seq[2] = ack;
        @(negedge clk); ack_seq[1] = ack;
        @(negedge clk); ack_seq[0] = ack;
        @(negedge clk); stb = 0;
        check("ack_held_pattern", {28'b0, ack_seq}, 32'h5);

        // Reset pulse mid-pattern.
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        check("led_after_reset", {30'b0, led}, 32'h3);
        bus(0, 0, 0, 8'h00);
        bus(0, 0, 1, 8'h00);
        bus(0, 1, 0, 8'h00);
        bus(0, 1, 1, 8'h00);
        wait_ticks(4);

        // Unmapped channel index 3 on the three-channel instance.
        bus3(1, 2'd3, 0, 8'hA5, rd, fa); check("oor_wr_mask_ack", {31'b0, fa}, 32'd1);
        bus3(1, 2'd3, 1, 8'h01, rd, fa); check("oor_wr_ctrl_ack", {31'b0, fa}, 32'd1);
        bus3(0, 2'd3, 0, 8'h00, rd, fa); check("oor_rd_mask_ack", {31'b0, fa}, 32'd1);
        check("oor_rd_mask", {24'b0, rd}, 32'h0);
        bus3(0, 2'd3, 1, 8'h00, rd, fa); check("oor_rd_ctrl", {24'b0, rd}, 32'h0);
        bus3(0, 2'd0, 0, 8'h00, rd, fa); check("oor_ch0_mask", {24'b0, rd}, 32'h0);
        bus3(0, 2'd2, 1, 8'h00, rd, fa); check("oor_ch2_ctrl", {24'b0, rd}, 32'h0);
        wait_ticks(3);
        check("oor_leds", {29'b0, led2}, 32'h7);
        bus3(1, 2'd2, 0, 8'h5A, rd, fa);
        bus3(0, 2'd2, 0, 8'h00, rd, fa); check("ch2_mask_rb", {24'b0, rd}, 32'h5A);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            stb = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1) != 0;
            adr = 2'($urandom_range(0, 3));
            dat = 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        stb = 0; rst = 0;
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
